// File: rtl/trace_mem_reader.sv
// Circular capture buffer holding the last DEPTH samples of a write stream.
// A dump freezes capture and streams the retained samples out oldest-first over valid/ready.
module trace_mem_reader #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  dump_req,
  output logic                  dump_busy,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [DEPTH_LOG2-1:0] out_index,
  output logic                  out_last,
  output logic [DEPTH_LOG2:0]   fill_count,
  output logic                  wr_dropped
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, DUMP} state_t;

  state_t                state, state_nxt;
  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2-1:0] start;
  logic [DEPTH_LOG2-1:0] idx_nxt;
  logic                  wr_accept;
  logic                  dump_accept;
  logic                  fire;

  assign dump_busy   = (state != IDLE);
  assign wr_accept   = (state == IDLE) && wr_en;
  // A write in the accepting cycle counts, so an empty buffer plus same-cycle write still dumps.
  assign dump_accept = (state == IDLE) && dump_req && ((fill_count != '0) || wr_en);
  assign fire        = (state == DUMP) && out_valid && out_ready;
  // Full buffer: low bits of fill_count are zero, so start lands on wr_ptr.
  assign start       = wr_ptr - fill_count[DEPTH_LOG2-1:0];
  assign idx_nxt     = out_index + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (dump_accept) state_nxt = LOAD;
      LOAD:    state_nxt = DUMP;
      DUMP:    if (fire && out_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_count <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_index  <= '0;
      out_last   <= 1'b0;
      wr_dropped <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (fill_count != FULL) fill_count <= fill_count + 1'b1;
      end

      if (wr_en && dump_busy) wr_dropped <= 1'b1;
      else if (dump_accept)   wr_dropped <= 1'b0;

      unique case (state)
        LOAD: begin
          out_data  <= mem[start];
          out_index <= '0;
          out_last  <= (fill_count == (DEPTH_LOG2 + 1)'(1));
          out_valid <= 1'b1;
          rd_ptr    <= start + 1'b1;
        end
        DUMP: begin
          if (fire) begin
            if (out_last) begin
              out_valid  <= 1'b0;
              out_last   <= 1'b0;
              fill_count <= '0;
            end else begin
              out_data  <= mem[rd_ptr];
              rd_ptr    <= rd_ptr + 1'b1;
              out_index <= idx_nxt;
              out_last  <= ({1'b0, idx_nxt} == fill_count - 1'b1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_trace_mem_reader.sv
// Directed bench for trace_mem_reader: table of fill/dump scenarios plus hand sequences
// for empty requests, same-cycle write+request, dropped-write clearing and reset mid-dump.
module tb_trace_mem_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       dump_req;
  logic       dump_busy;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [3:0] out_index;
  logic       out_last;
  logic [4:0] fill_count;
  logic       wr_dropped;

  int vecs = 0;
  int errs = 0;

  trace_mem_reader #(.WIDTH(8), .DEPTH_LOG2(4)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .dump_req(dump_req), .dump_busy(dump_busy), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_index(out_index),
    .out_last(out_last), .fill_count(fill_count), .wr_dropped(wr_dropped)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         n_wr;
    logic [7:0] base;
    bit         bp;
    bit         wrdur;
    int         exp_fill;
    logic [7:0] exp_first;
    int         exp_n;
    bit         exp_drop;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_en = 1'b0; wr_data = '0; dump_req = 1'b0; out_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic write_seq(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      wr_en = 1'b1;
      wr_data = base + 8'(i);
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic run_dump(input bit bp, input bit wrdur, input bit same_wr,
                          input logic [7:0] same_val, input logic [7:0] exp_first,
                          input int exp_n, input bit exp_drop);
    int t, beat, cyc;
    logic [7:0] hd, e;
    logic [3:0] hi;
    logic hl;
    bit stalled;
    dump_req = 1'b1; wr_en = same_wr; wr_data = same_val;
    tick();
    dump_req = 1'b0; wr_en = wrdur; wr_data = 8'hEE;
    chk("busy_load", dump_busy, 1);
    t = 0;
    while (!out_valid && t < 10) begin tick(); t++; end
    chk("valid_up", out_valid, 1);
    beat = 0; cyc = 0; stalled = 0; hd = '0; hi = '0; hl = 0;
    while (out_valid && cyc < 400) begin
      if (stalled) begin
        chk("stall_data", out_data, hd);
        chk("stall_index", out_index, hi);
        chk("stall_last", out_last, hl);
      end
      out_ready = bp ? (cyc % 3 == 0) : 1'b1;
      if (out_ready) begin
        e = exp_first + 8'(beat);
        chk("beat_data", out_data, e);
        chk("beat_index", out_index, beat);
        chk("beat_last", out_last, beat == exp_n - 1);
        beat++;
        stalled = 0;
      end else begin
        hd = out_data; hi = out_index; hl = out_last; stalled = 1;
      end
      tick();
      cyc++;
    end
    out_ready = 1'b0; wr_en = 1'b0;
    chk("beat_count", beat, exp_n);
    chk("busy_after", dump_busy, 0);
    chk("valid_after", out_valid, 0);
    chk("fill_after", fill_count, 0);
    chk("dropped", wr_dropped, exp_drop);
  endtask

  initial begin
    tbl[0] = '{n_wr: 5,  base: 8'd0,   bp: 0, wrdur: 0, exp_fill: 5,  exp_first: 8'd0,   exp_n: 5,  exp_drop: 0};
    tbl[1] = '{n_wr: 20, base: 8'd0,   bp: 0, wrdur: 0, exp_fill: 16, exp_first: 8'd4,   exp_n: 16, exp_drop: 0};
    tbl[2] = '{n_wr: 16, base: 8'd100, bp: 1, wrdur: 0, exp_fill: 16, exp_first: 8'd100, exp_n: 16, exp_drop: 0};
    tbl[3] = '{n_wr: 10, base: 8'd50,  bp: 0, wrdur: 1, exp_fill: 10, exp_first: 8'd50,  exp_n: 10, exp_drop: 1};
    tbl[4] = '{n_wr: 17, base: 8'd200, bp: 1, wrdur: 1, exp_fill: 16, exp_first: 8'd201, exp_n: 16, exp_drop: 1};
    tbl[5] = '{n_wr: 1,  base: 8'd7,   bp: 0, wrdur: 0, exp_fill: 1,  exp_first: 8'd7,   exp_n: 1,  exp_drop: 0};

    do_reset();
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", dump_busy, 0);
    chk("rst_fill", fill_count, 0);
    chk("rst_dropped", wr_dropped, 0);
    chk("rst_data", out_data, 0);
    chk("rst_index", out_index, 0);
    chk("rst_last", out_last, 0);

    for (int v = 0; v < 6; v++) begin
      do_reset();
      write_seq(tbl[v].n_wr, tbl[v].base);
      chk("fill_pre", fill_count, tbl[v].exp_fill);
      run_dump(tbl[v].bp, tbl[v].wrdur, 1'b0, 8'h00, tbl[v].exp_first, tbl[v].exp_n, tbl[v].exp_drop);
    end

    // Empty request is ignored
    do_reset();
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    chk("empty_busy", dump_busy, 0);
    tick();
    chk("empty_busy2", dump_busy, 0);
    chk("empty_valid", out_valid, 0);

    // Same-cycle write and request on an empty buffer gives a one-beat dump
    run_dump(1'b0, 1'b0, 1'b1, 8'd42, 8'd42, 1, 1'b0);

    // wr_dropped set by one dump clears when the next dump reaches LOAD
    do_reset();
    write_seq(3, 8'd10);
    run_dump(1'b0, 1'b1, 1'b0, 8'h00, 8'd10, 3, 1'b1);
    write_seq(2, 8'd30);
    chk("dropped_held", wr_dropped, 1);
    run_dump(1'b0, 1'b0, 1'b0, 8'h00, 8'd30, 2, 1'b0);

    // Reset after three accepted beats of a 16-beat dump
    do_reset();
    write_seq(16, 8'd0);
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0; wr_en = 1'b1; wr_data = 8'hEE;
    tick();
    chk("mid_valid_up", out_valid, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("mid_index", out_index, 3);
    chk("mid_dropped", wr_dropped, 1);
    rst = 1'b1; wr_en = 1'b0; out_ready = 1'b0;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", dump_busy, 0);
    chk("mid_rst_fill", fill_count, 0);
    chk("mid_rst_dropped", wr_dropped, 0);
    out_ready = 1'b1;
    tick();
    chk("mid_rst_quiet", out_valid, 0);
    out_ready = 1'b0;
    write_seq(1, 8'd77);
    chk("mid_refill", fill_count, 1);
    run_dump(1'b0, 1'b0, 1'b0, 8'h00, 8'd77, 1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
